// File: rtl/segmented_memory.sv
// Segmented word store with scalar (64-bit) and packed 4x16 vector views.
// Synchronous write per segment, registered read with a one-cycle valid strobe.
module segmented_memory #(
    parameter int unsigned NUM_SEGS  = 4,
    parameter int unsigned SEG_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [63:0]       address,
    input  logic [63:0]       data_in,
    input  logic [3:0][15:0]  vect_in,
    input  logic              read,
    input  logic              write,
    input  logic              vect,
    output logic [63:0]       data_out,
    output logic [3:0][15:0]  vect_out,
    output logic              valid
);

    localparam int unsigned OFF_W = (SEG_WORDS > 1) ? $clog2(SEG_WORDS) : 1;
    localparam int unsigned SEG_W = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
    localparam logic [60:0] TOTAL_WORDS = 61'(NUM_SEGS * SEG_WORDS);

    logic [60:0]      word_idx;
    logic             in_range;
    logic [OFF_W-1:0] offset;
    logic [SEG_W-1:0] seg_sel;
    logic [63:0]      wdata;
    logic [63:0]      rdata;
    logic [63:0]      seg_rdata [NUM_SEGS];
    logic             addr_lsb_unused;

    // Byte-lane bits are dropped: every access is a whole aligned word.
    assign word_idx        = address[63:3];
    assign addr_lsb_unused = ^address[2:0];
    assign in_range        = (word_idx < TOTAL_WORDS);
    assign offset          = word_idx[OFF_W-1:0];
    assign seg_sel         = word_idx[OFF_W +: SEG_W];
    assign wdata           = vect ? 64'(vect_in) : data_in;

    for (genvar s = 0; s < NUM_SEGS; s++) begin : g_seg
        logic [63:0] mem [SEG_WORDS];
        logic        seg_en;

        assign seg_en = in_range && (seg_sel == SEG_W'(s));

        always_ff @(posedge clk) begin
            if (rst_n && write && seg_en) begin
                mem[offset] <= wdata;
            end
        end

        assign seg_rdata[s] = mem[offset];
    end

    always_comb begin
        rdata = '0;
        for (int unsigned s = 0; s < NUM_SEGS; s++) begin
            if (seg_sel == SEG_W'(s)) begin
                rdata = seg_rdata[s];
            end
        end
    end

    // A simultaneous write wins: no read happens and the outputs hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            vect_out <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (read && !write) begin
                if (in_range) begin
                    data_out <= rdata;
                    vect_out <= rdata;
                    valid    <= 1'b1;
                end else begin
                    data_out <= '0;
                    vect_out <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_segmented_memory.sv
// Testbench for segmented_memory: directed vector table, corner sequences,
// and randomized traffic checked against an associative-array memory model.
module tb_segmented_memory;

    localparam longint unsigned TOTAL_WORDS = 4 * 256;

    logic              clk;
    logic              rst_n;
    logic [63:0]       address;
    logic [63:0]       data_in;
    logic [3:0][15:0]  vect_in;
    logic              read;
    logic              write;
    logic              vect;
    logic [63:0]       data_out;
    logic [3:0][15:0]  vect_out;
    logic              valid;

    segmented_memory #(.NUM_SEGS(4), .SEG_WORDS(256)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .address  (address),
        .data_in  (data_in),
        .vect_in  (vect_in),
        .read     (read),
        .write    (write),
        .vect     (vect),
        .data_out (data_out),
        .vect_out (vect_out),
        .valid    (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: word index -> stored word, plus the expected output registers.
    logic [63:0] model_mem [longint unsigned];
    logic [63:0] exp_data  = '0;
    logic        exp_valid = 1'b0;

    typedef struct {
        string       name;
        bit          rd;
        bit          wr;
        bit          vec;
        logic [63:0] addr;
        logic [63:0] din;
        logic [63:0] vin;
        logic [63:0] exp_data;
        bit          exp_valid;
    } vec_t;

    vec_t tbl [$];

    task automatic add_vec(string name, bit rd, bit wr, bit vec, logic [63:0] a,
                           logic [63:0] d, logic [63:0] v, logic [63:0] ed, bit ev);
        vec_t t;
        t.name = name; t.rd = rd; t.wr = wr; t.vec = vec; t.addr = a;
        t.din = d; t.vin = v; t.exp_data = ed; t.exp_valid = ev;
        tbl.push_back(t);
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(string name, logic [63:0] ed, bit ev);
        check({name, " data_out"}, data_out, ed);
        check({name, " vect_out"}, 64'(vect_out), ed);
        check({name, " valid"}, {63'd0, valid}, {63'd0, ev});
    endtask

    // Drive one request, clock it, and advance the model by the same request.
    task automatic step(bit rd, bit wr, bit vec, logic [63:0] a, logic [63:0] d, logic [63:0] v);
        longint unsigned idx;
        bit inr;
        @(negedge clk);
        read = rd; write = wr; vect = vec; address = a; data_in = d; vect_in = v;
        @(posedge clk);
        #1;
        idx = longint'(a >> 3);
        inr = idx < TOTAL_WORDS;
        if (wr) begin
            if (inr) model_mem[idx] = vec ? v : d;
            exp_valid = 1'b0;
        end else if (rd) begin
            if (inr) begin
                exp_data  = model_mem.exists(idx) ? model_mem[idx] : 64'd0;
                exp_valid = 1'b1;
            end else begin
                exp_data  = '0;
                exp_valid = 1'b0;
            end
        end else begin
            exp_valid = 1'b0;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; read = 1'b0; write = 1'b0; vect = 1'b0;
        address = '0; data_in = '0; vect_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 64'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        add_vec("vwr512",   0, 1, 1, 64'd512,  64'hFFFF0000FFFF0000, 64'hAAAABBBBCCCCDDDD, 64'd0, 0);
        add_vec("vrd512",   1, 0, 1, 64'd512,  64'd0, 64'd0, 64'hAAAABBBBCCCCDDDD, 1);
        add_vec("idle",     0, 0, 0, 64'd512,  64'd0, 64'd0, 64'hAAAABBBBCCCCDDDD, 0);
        add_vec("swr512",   0, 1, 0, 64'd512,  64'h123456789ABCDEF0, 64'h5555555555555555, 64'hAAAABBBBCCCCDDDD, 0);
        add_vec("svrd512",  1, 0, 1, 64'd512,  64'd0, 64'd0, 64'h123456789ABCDEF0, 1);
        add_vec("wr0",      0, 1, 0, 64'd0,    64'h11, 64'h5555555555555555, 64'h123456789ABCDEF0, 0);
        add_vec("wr2048",   0, 1, 0, 64'd2048, 64'h22, 64'h5555555555555555, 64'h123456789ABCDEF0, 0);
        add_vec("rd0",      1, 0, 0, 64'd0,    64'd0, 64'd0, 64'h11, 1);
        add_vec("rd2048",   1, 0, 0, 64'd2048, 64'd0, 64'd0, 64'h22, 1);
        add_vec("rd2052",   1, 0, 0, 64'd2052, 64'd0, 64'd0, 64'h22, 1);
        add_vec("wr8192",   0, 1, 0, 64'd8192, 64'hDEAD, 64'd0, 64'h22, 0);
        add_vec("rd8192",   1, 0, 0, 64'd8192, 64'd0, 64'd0, 64'd0, 0);
        add_vec("rd0_keep", 1, 0, 0, 64'd0,    64'd0, 64'd0, 64'h11, 1);
        add_vec("rw8",      1, 1, 0, 64'd8,    64'hFF, 64'd0, 64'h11, 0);
        add_vec("rd8",      1, 0, 0, 64'd8,    64'd0, 64'd0, 64'hFF, 1);
        add_vec("wr8184",   0, 1, 0, 64'd8184, 64'hC0FFEE, 64'd0, 64'hFF, 0);
        add_vec("rd8191",   1, 0, 0, 64'd8191, 64'd0, 64'd0, 64'hC0FFEE, 1);
        add_vec("wrhigh",   0, 1, 0, 64'h8000000000000200, 64'h77, 64'd0, 64'hC0FFEE, 0);
        add_vec("rd512_hi", 1, 0, 0, 64'd512,  64'd0, 64'd0, 64'h123456789ABCDEF0, 1);
        add_vec("rdhigh",   1, 0, 0, 64'h8000000000000200, 64'd0, 64'd0, 64'd0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rd, tbl[i].wr, tbl[i].vec, tbl[i].addr, tbl[i].din, tbl[i].vin);
            check_outputs(tbl[i].name, tbl[i].exp_data, tbl[i].exp_valid);
        end

        // Lane view of a scalar-written word.
        step(1, 0, 1, 64'd512, 64'd0, 64'd0);
        check("lane3", {48'd0, vect_out[3]}, 64'h1234);
        check("lane2", {48'd0, vect_out[2]}, 64'h5678);
        check("lane1", {48'd0, vect_out[1]}, 64'h9ABC);
        check("lane0", {48'd0, vect_out[0]}, 64'hDEF0);

        // Asynchronous reset mid-operation; requests during reset are ignored.
        step(1, 0, 0, 64'd2048, 64'd0, 64'd0);
        check_outputs("pre_rst", 64'h22, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 64'd0, 1'b0);
        read = 1'b0; write = 1'b1; vect = 1'b0; address = 64'd2048; data_in = 64'hBAD;
        @(posedge clk);
        #1;
        check_outputs("in_rst", 64'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; write = 1'b0;
        exp_data = '0; exp_valid = 1'b0;
        step(1, 0, 0, 64'd2048, 64'd0, 64'd0);
        check_outputs("post_rst", 64'h22, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            int unsigned op;
            bit rd, wr, vec;
            logic [63:0] a, d, v;
            longint unsigned w;
            op  = $urandom_range(0, 9);
            vec = 1'($urandom_range(0, 1));
            d   = {$urandom, $urandom};
            v   = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) begin
                a = 64'd8192 + 64'($urandom_range(0, 100000));
                if ($urandom_range(0, 1) == 1) a[63:40] = 24'($urandom | 1);
            end else begin
                w = longint'($urandom_range(0, 3)) * 256 +
                    (($urandom_range(0, 1) == 1) ? longint'($urandom_range(0, 7))
                                                 : 255 - longint'($urandom_range(0, 7)));
                a = {w[60:0], 3'($urandom_range(0, 7))};
            end
            rd = (op >= 4 && op <= 8);
            wr = (op <= 3 || op == 8);
            if (rd && !wr && (a >> 3) < TOTAL_WORDS && !model_mem.exists(longint'(a >> 3))) begin
                rd = 1'b0;
                wr = 1'b1;
            end
            step(rd, wr, vec, a, d, v);
            check_outputs("rand", exp_data, exp_valid);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
